// File: rtl/id_alu_issue.sv
// Decode RV64I instructions into ALU operands/opcode/branch select for EX,
// buffered in a 2-entry skid FIFO. out_imm holds the instruction's format immediate (0 for R-type).
module id_alu_issue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [11:0]     out_alu_info,
  output logic            out_is_word,
  output logic [7:0]      out_bj_sel,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP = 7'b0110011, OPC_OPIMM32 = 7'b0011011, OPC_OP32 = 7'b0111011;
  localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_SLT = 12'h004, A_SLTU = 12'h008,
                          A_XOR = 12'h010, A_OR = 12'h020, A_AND = 12'h040, A_SLL = 12'h080,
                          A_SRL = 12'h100, A_SRA = 12'h200, A_WRI = 12'h800;
  localparam logic [1:0] L_FULL = 2'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [11:0]     alu;
    logic            word;
    logic [7:0]      bj;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } t_entry;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
  t_entry          w_ent, w_head;
  logic            w_push, w_pop;

  t_entry          r_mem [DEPTH];
  logic            r_wr_ptr, r_rd_ptr;
  logic [1:0]      r_count;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_f7    = in_inst[31:25];
  assign w_imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    w_ent      = '0;
    w_ent.wen  = 1'b1;
    w_ent.rd   = in_inst[11:7];
    w_ent.pc   = in_pc;
    case (w_opc)
      OPC_LUI: begin
        w_ent.alu = A_WRI; w_ent.op2 = w_imm_u; w_ent.imm = w_imm_u;
      end
      OPC_AUIPC: begin
        w_ent.alu = A_ADD; w_ent.op1 = in_pc; w_ent.op2 = w_imm_u; w_ent.imm = w_imm_u;
      end
      OPC_JAL: begin
        w_ent.alu = A_ADD; w_ent.op1 = in_pc; w_ent.op2 = XLEN'(4);
        w_ent.bj  = 8'h80; w_ent.imm = w_imm_j;
      end
      OPC_JALR: begin
        w_ent.alu = A_ADD; w_ent.op1 = in_pc; w_ent.op2 = XLEN'(4);
        w_ent.bj  = 8'h40; w_ent.imm = w_imm_i;
        w_ent.ill = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_ent.op1 = in_rs1_data; w_ent.op2 = in_rs2_data; w_ent.wen = 1'b0; w_ent.imm = w_imm_b;
        case (w_f3)
          3'b000:  begin w_ent.alu = A_XOR;  w_ent.bj = 8'h01; end
          3'b001:  begin w_ent.alu = A_XOR;  w_ent.bj = 8'h02; end
          3'b100:  begin w_ent.alu = A_SLT;  w_ent.bj = 8'h04; end
          3'b101:  begin w_ent.alu = A_SLT;  w_ent.bj = 8'h08; end
          3'b110:  begin w_ent.alu = A_SLTU; w_ent.bj = 8'h10; end
          3'b111:  begin w_ent.alu = A_SLTU; w_ent.bj = 8'h20; end
          default: w_ent.ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_ent.op1 = in_rs1_data; w_ent.op2 = w_imm_i; w_ent.imm = w_imm_i;
        case (w_f3)
          3'b000: w_ent.alu = A_ADD;
          3'b010: w_ent.alu = A_SLT;
          3'b011: w_ent.alu = A_SLTU;
          3'b100: w_ent.alu = A_XOR;
          3'b110: w_ent.alu = A_OR;
          3'b111: w_ent.alu = A_AND;
          3'b001: begin
            w_ent.op2 = XLEN'(in_inst[25:20]);
            if (in_inst[31:26] == 6'b000000) w_ent.alu = A_SLL;
            else w_ent.ill = 1'b1;
          end
          default: begin
            w_ent.op2 = XLEN'(in_inst[25:20]);
            if (in_inst[31:26] == 6'b000000) w_ent.alu = A_SRL;
            else if (in_inst[31:26] == 6'b010000) w_ent.alu = A_SRA;
            else w_ent.ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        w_ent.op1 = in_rs1_data; w_ent.op2 = in_rs2_data;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_ent.alu = A_ADD;
            3'b001:  w_ent.alu = A_SLL;
            3'b010:  w_ent.alu = A_SLT;
            3'b011:  w_ent.alu = A_SLTU;
            3'b100:  w_ent.alu = A_XOR;
            3'b101:  w_ent.alu = A_SRL;
            3'b110:  w_ent.alu = A_OR;
            default: w_ent.alu = A_AND;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_ent.alu = A_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_ent.alu = A_SRA;
        else w_ent.ill = 1'b1;
      end
      OPC_OPIMM32: begin
        w_ent.word = 1'b1; w_ent.op1 = in_rs1_data; w_ent.op2 = w_imm_i; w_ent.imm = w_imm_i;
        if (w_f3 == 3'b000) w_ent.alu = A_ADD;
        else if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // 5-bit shamt; inst[25] set would be a 64-bit shift amount
          w_ent.op2 = XLEN'(in_inst[24:20]);
          if (w_f7 == 7'b0000000) w_ent.alu = (w_f3 == 3'b001) ? A_SLL : A_SRL;
          else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_ent.alu = A_SRA;
          else w_ent.ill = 1'b1;
        end else w_ent.ill = 1'b1;
      end
      OPC_OP32: begin
        w_ent.word = 1'b1; w_ent.op1 = in_rs1_data; w_ent.op2 = in_rs2_data;
        if (w_f7 == 7'b0000000 && w_f3 == 3'b000) w_ent.alu = A_ADD;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b001) w_ent.alu = A_SLL;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b101) w_ent.alu = A_SRL;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_ent.alu = A_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_ent.alu = A_SRA;
        else w_ent.ill = 1'b1;
      end
      default: w_ent.ill = 1'b1;
    endcase
    if (w_ent.ill) begin
      w_ent.alu = '0; w_ent.bj = '0; w_ent.wen = 1'b0;
    end
    if (w_ent.rd == 5'd0) w_ent.wen = 1'b0;
  end

  assign in_ready  = (r_count != L_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ent;
  end

  // Payload is forced to zero when the FIFO is empty
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_op1      = w_head.op1;
  assign out_op2      = w_head.op2;
  assign out_alu_info = w_head.alu;
  assign out_is_word  = w_head.word;
  assign out_bj_sel   = w_head.bj;
  assign out_rd       = w_head.rd;
  assign out_rd_wen   = w_head.wen;
  assign out_imm      = w_head.imm;
  assign out_pc       = w_head.pc;
  assign out_illegal  = w_head.ill;
endmodule

// File: tb/tb_id_alu_issue.sv
// Directed vector bench for id_alu_issue: decode table plus FIFO backpressure/flush/reset sequences.
module tb_id_alu_issue;
  localparam int PW = 285;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111, OPIMM = 7'b0010011,
                         OP = 7'b0110011, OPIMM32 = 7'b0011011, OP32 = 7'b0111011;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data;
  logic [63:0] out_op1, out_op2, out_imm, out_pc;
  logic [11:0] out_alu_info;
  logic        out_is_word, out_rd_wen, out_illegal;
  logic [7:0]  out_bj_sel;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  id_alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_alu_info(out_alu_info), .out_is_word(out_is_word), .out_bj_sel(out_bj_sel),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, rs1, rs2, op1, op2;
    logic [11:0] alu;
    logic        word;
    logic [7:0]  bj;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] imm;
    logic        ill;
    bit          full;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  logic [PW-1:0] w_act;
  logic [22:0]   w_small;
  assign w_act   = {out_valid, out_op1, out_op2, out_alu_info, out_is_word, out_bj_sel, out_rd,
                    out_rd_wen, out_imm, out_pc, out_illegal};
  assign w_small = {out_valid, out_alu_info, out_bj_sel, out_rd_wen, out_illegal};

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [63:0] op1, input logic [63:0] op2,
                              input logic [11:0] alu, input logic word, input logic [7:0] bj,
                              input logic [4:0] rd, input logic wen, input logic [63:0] imm,
                              input logic ill, input bit full);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.op1 = op1; v.op2 = op2; v.alu = alu;
    v.word = word; v.bj = bj; v.rd = rd; v.wen = wen; v.imm = imm; v.ill = ill; v.full = full;
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2);
    in_inst = inst; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  logic [31:0] addi_x1;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 64'h0, 64'h0, 64'h0);
    addi_x1 = enc_i(12'h001, 5'd0, 3'b000, 5'd1, OPIMM);

    vecs.push_back(mk(enc_i(12'hFFF, 5'd1, 3'b000, 5'd5, OPIMM), 64'h100, 64'h10, 64'h99,
                      64'h10, '1, 12'h001, 0, 8'h00, 5'd5, 1, '1, 0, 1));
    vecs.push_back(mk(enc_r(7'b0100000, 5'd31, 5'd2, 3'b101, 5'd3, OPIMM32), 64'h104, 64'h1234, 64'h0,
                      64'h1234, 64'd31, 12'h200, 1, 8'h00, 5'd3, 1, 64'h41F, 0, 1));
    vecs.push_back(mk(enc_r(7'b0100001, 5'd31, 5'd2, 3'b101, 5'd3, OPIMM32), 64'h108, 64'h1234, 64'h0,
                      64'h0, 64'h0, 12'h000, 0, 8'h00, 5'd0, 0, 64'h0, 1, 0));
    vecs.push_back(mk(enc_b(13'd16, 5'd2, 5'd1, 3'b110), 64'h10C, 64'd1, 64'd2,
                      64'd1, 64'd2, 12'h008, 0, 8'h10, 5'd16, 0, 64'd16, 0, 1));
    vecs.push_back(mk(enc_b(13'd16, 5'd2, 5'd1, 3'b101), 64'h110, 64'hFF, 64'h3,
                      64'hFF, 64'h3, 12'h004, 0, 8'h08, 5'd16, 0, 64'd16, 0, 1));
    vecs.push_back(mk(enc_j(21'h800, 5'd1), 64'h8000_0000, 64'h5, 64'h6,
                      64'h8000_0000, 64'd4, 12'h001, 0, 8'h80, 5'd1, 1, 64'h800, 0, 1));
    vecs.push_back(mk(enc_i(12'hFFC, 5'd2, 3'b000, 5'd1, JALR), 64'h40, 64'h7, 64'h8,
                      64'h40, 64'd4, 12'h001, 0, 8'h40, 5'd1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1));
    vecs.push_back(mk({20'hABCDE, 5'd0, LUI}, 64'h44, 64'h1, 64'h2,
                      64'h0, 64'hFFFF_FFFF_ABCD_E000, 12'h800, 0, 8'h00, 5'd0, 0,
                      64'hFFFF_FFFF_ABCD_E000, 0, 1));
    vecs.push_back(mk({20'h00001, 5'd7, AUIPC}, 64'h2000, 64'h1, 64'h2,
                      64'h2000, 64'h1000, 12'h001, 0, 8'h00, 5'd7, 1, 64'h1000, 0, 1));
    vecs.push_back(mk(enc_r(7'b0100000, 5'd12, 5'd11, 3'b000, 5'd10, OP), 64'h48, 64'd5, 64'd3,
                      64'd5, 64'd3, 12'h002, 0, 8'h00, 5'd10, 1, 64'h0, 0, 1));
    vecs.push_back(mk(enc_i(12'd5, 5'd1, 3'b011, 5'd4, OPIMM), 64'h4C, 64'd7, 64'd0,
                      64'd7, 64'd5, 12'h008, 0, 8'h00, 5'd4, 1, 64'd5, 0, 1));
    vecs.push_back(mk(enc_i(12'h43F, 5'd7, 3'b101, 5'd6, OPIMM), 64'h50, '1, 64'd0,
                      '1, 64'd63, 12'h200, 0, 8'h00, 5'd6, 1, 64'h43F, 0, 1));
    vecs.push_back(mk(enc_i(12'hFFE, 5'd9, 3'b000, 5'd8, OPIMM32), 64'h54, 64'd3, 64'd0,
                      64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 12'h001, 1, 8'h00, 5'd8, 1,
                      64'hFFFF_FFFF_FFFF_FFFE, 0, 1));
    vecs.push_back(mk(enc_r(7'b0000000, 5'd3, 5'd2, 3'b001, 5'd1, OP32), 64'h58, 64'h11, 64'h22,
                      64'h11, 64'h22, 12'h080, 1, 8'h00, 5'd1, 1, 64'h0, 0, 1));
    vecs.push_back(mk(enc_i(12'h0F0, 5'd3, 3'b111, 5'd2, OPIMM), 64'h5C, 64'h1FF, 64'd0,
                      64'h1FF, 64'hF0, 12'h040, 0, 8'h00, 5'd2, 1, 64'hF0, 0, 1));
    vecs.push_back(mk(enc_b(13'd16, 5'd2, 5'd1, 3'b010), 64'h60, 64'd1, 64'd2,
                      64'h0, 64'h0, 12'h000, 0, 8'h00, 5'd0, 0, 64'h0, 1, 0));
    vecs.push_back(mk(32'h0, 64'h64, 64'd1, 64'd2,
                      64'h0, 64'h0, 12'h000, 0, 8'h00, 5'd0, 0, 64'h0, 1, 0));
    vecs.push_back(mk(enc_r(7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1, OP), 64'h68, 64'd1, 64'd2,
                      64'h0, 64'h0, 12'h000, 0, 8'h00, 5'd0, 0, 64'h0, 1, 0));
    vecs.push_back(mk(enc_i(12'h045, 5'd2, 3'b001, 5'd1, OPIMM), 64'h6C, 64'd1, 64'd2,
                      64'h0, 64'h0, 12'h000, 0, 8'h00, 5'd0, 0, 64'h0, 1, 0));

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_hs", PW'({in_ready, out_valid}), PW'(2'b10));
    chk("reset_payload", w_act, '0);

    // decode table, streamed back-to-back so every cycle is push+pop at count 1
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      drive(vecs[k].inst, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      in_valid = 1'b1;
      @(negedge clk);
      if (vecs[k].full)
        chk($sformatf("vec%0d", k), w_act,
            PW'({1'b1, vecs[k].op1, vecs[k].op2, vecs[k].alu, vecs[k].word, vecs[k].bj, vecs[k].rd,
                 vecs[k].wen, vecs[k].imm, vecs[k].pc, vecs[k].ill}));
      else
        chk($sformatf("vec%0d_illegal", k), PW'(w_small),
            PW'({1'b1, vecs[k].alu, vecs[k].bj, vecs[k].wen, vecs[k].ill}));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_empty", PW'({out_valid, in_ready}), PW'(2'b01));

    // backpressure: A,B fill the FIFO, C is held until a slot frees
    out_ready = 1'b0;
    drive(addi_x1, 64'h0, 64'hA, 64'h0); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_A", PW'(in_ready), PW'(1'b1));
    drive(addi_x1, 64'h0, 64'hB, 64'h0);
    @(negedge clk);
    chk("bp_full", PW'({in_ready, out_valid}), PW'(2'b01));
    chk("bp_head_A", PW'(out_op1), PW'(64'hA));
    drive(addi_x1, 64'h0, 64'hC, 64'h0);
    @(negedge clk);
    chk("bp_held", PW'({in_ready, out_op1}), PW'({1'b0, 64'hA}));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_no_push", PW'({in_ready, out_op1}), PW'({1'b1, 64'hB}));
    @(negedge clk);
    chk("bp_pushpop_count1", PW'({in_ready, out_valid, out_op1}), PW'({2'b11, 64'hC}));
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", PW'({out_valid, out_op1}), PW'({1'b0, 64'h0}));

    // flush at count 2 with an incoming entry
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_full", PW'(in_ready), PW'(1'b0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count2", PW'({in_ready, out_valid}), PW'(2'b10));
    chk("fl_count2_payload", w_act, '0);

    // flush at count 1: the same-cycle push must be dropped
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    drive(addi_x1, 64'h0, 64'hD, 64'h0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_push_dropped", PW'({in_ready, out_valid}), PW'(2'b10));
    @(negedge clk);
    chk("fl_stays_empty", PW'(out_valid), PW'(1'b0));

    // reset mid-stream with the FIFO full
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_full", PW'(in_ready), PW'(1'b0));
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_hs", PW'({in_ready, out_valid}), PW'(2'b10));
    chk("rst_mid_payload", w_act, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_alu_issue.md
Name: id_alu_issue

Overview:
- Decode-side producer for the EX-stage ALU interface.
- Takes RV64I instructions with their operand register values and decodes each one into ALU operands, a one-hot ALU opcode (alu_info), the word-op flag and a one-hot branch/jump select aligned with the ALU's bj_data vector.
- Sits between the register-read stage and EX. Results are buffered in a 2-entry skid FIFO with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, operand width.
- DEPTH, 2, skid FIFO entries (fixed 2; other values unsupported).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all buffered and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  FIFO can accept; equals (count != 2)
- in_inst  in  32  instruction word
- in_pc  in  64  instruction PC
- in_rs1_data  in  64  rs1 value
- in_rs2_data  in  64  rs2 value
- out_valid  out  1  head entry valid; equals (count != 0)
- out_ready  in  1  EX accepts head
- out_op1  out  64  ALU operand 1
- out_op2  out  64  ALU operand 2
- out_alu_info  out  12  one-hot: [0]ADD [1]SUB [2]SLT [3]SLTU [4]XOR [5]OR [6]AND [7]SLL [8]SRL [9]SRA [10]ANDN [11]WRI
- out_is_word  out  1  32-bit (W) operation
- out_bj_sel  out  8  one-hot: [0]BEQ [1]BNE [2]BLT [3]BGE [4]BLTU [5]BGEU [6]JALR [7]JAL; zero for non-control
- out_rd  out  5  destination register
- out_rd_wen  out  1  writes rd (forced 0 when rd==0)
- out_imm  out  64  sign-extended immediate (branch/jump target offset)
- out_pc  out  64  PC passthrough
- out_illegal  out  1  unsupported/illegal encoding

Behaviour:
- Decode is combinational on the input side; decoded results are written into the FIFO on push. Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- Outputs are driven from the head entry. Latency is 1 cycle from push to out_valid.
- Reset: count=0, wr/rd pointers=0, every out_* = 0, in_ready=1, out_valid=0.
- Payload outputs are 0 whenever count==0.
- Simultaneous push and pop at count==1: count stays 1 and head advances.
- At count==2, in_ready=0. A concurrent pop does not enable same-cycle push.
- Flush: next cycle count=0 and pointers=0; a same-cycle push is discarded. Flush and rst are equivalent except rst also has priority.
- Decode table:
  - LUI: WRI, op2=U-imm.
  - AUIPC: ADD, op1=pc, op2=U-imm.
  - JAL: ADD, op1=pc, op2=4, bj_sel JAL, imm=J-imm.
  - JALR (funct3 0): ADD, op1=pc, op2=4, bj_sel JALR, imm=I-imm.
  - BRANCH: op1=rs1, op2=rs2, rd_wen=0, imm=B-imm.
    - BEQ/BNE use XOR.
    - BLT/BGE use SLT.
    - BLTU/BGEU use SLTU.
    - bj_sel per funct3. funct3 010/011 is illegal.
  - OP-IMM: op1=rs1, op2=I-imm. Opcode by funct3: ADDI ADD, SLTI SLT, SLTIU SLTU, XORI XOR, ORI OR, ANDI AND.
  - OP-IMM shifts: SLLI/SRLI/SRAI with 6-bit shamt. inst[31:26] must be 000000, or 010000 for SRAI; anything else is illegal.
  - OP: funct7 0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7 0100000 gives SUB (f3 000) and SRA (f3 101); others are illegal.
  - OP-IMM-32: ADDIW/SLLIW/SRLIW/SRAIW, is_word=1. Shamt is 5 bits; inst[25]=1 is illegal.
  - OP-32: ADDW/SUBW/SLLW/SRLW/SRAW, is_word=1.
  - Any other opcode: illegal.
- Illegal entries are still enqueued, with alu_info=0, bj_sel=0, rd_wen=0 and illegal=1.
- Immediates are sign-extended to 64 bits from inst[31]. U-imm = {sext(inst[31:12]), 12'b0}.

Test Plan:
- Reset mid-stream: rst with count==2 -> next cycle out_valid=0, in_ready=1, all out_*=0.
- ADDI x5,x1,-1 with rs1=0x10 -> out_alu_info=0x001, op1=0x10, op2=0xFFFF_FFFF_FFFF_FFFF, rd=5, rd_wen=1, one cycle after push.
- SRAIW x3,x2,31 (inst[25]=0) -> alu_info=0x200, is_word=1, op2[4:0]=31. Same encoding with inst[25]=1 -> illegal=1, alu_info=0.
- BLTU rs1=1, rs2=2 -> alu_info=0x008, bj_sel=0x10, rd_wen=0, imm=B-imm. JAL pc=0x8000_0000 -> ADD, op1=pc, op2=4, bj_sel=0x80.
- Backpressure: out_ready=0, push 3 entries -> in_ready falls after 2nd push, 3rd held. Release -> entries pop in order A,B,C; push+pop at count==1 keeps count 1.
- Flush with count==2 and in_valid=1 -> next cycle count=0, incoming entry dropped. LUI x0 -> rd_wen=0.
